approx_ha_array_mul_seq: RTL and testbench

Sequential, parametrised successor to the 8x8 half-adder-array approximate multiplier. The partial-product matrix of an unsigned WIDTH x WIDTH multiply is split into WIDTH/2 row pairs. Each row pair is reduced by one row of configurable approximate half adders, one pair per cycle. The reduced pair is weighted and accumulated into a 2*WIDTH-bit product. The block sits in the approximate-arithmetic datapath behind a valid/ready handshake, and trades latency for a single reusable HA row.

---
 rtl/approx_ha_array_mul_seq_if.sv | 23 ++
 rtl/approx_ha_array_mul_seq.sv | 138 +++++++++++++
 tb/tb_approx_ha_array_mul_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/approx_ha_array_mul_seq_if.sv
// Operand/product handshake bundle for approx_ha_array_mul_seq.
// The master drives operands and the product-accept strobe; the multiplier is the slave.
interface approx_ha_array_mul_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   p;

    modport master (
        output in_valid, x, y, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, x, y, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/approx_ha_array_mul_seq.sv
// Sequential approximate multiplier: one partial-product row pair reduced by a configurable HA row per cycle.
// Optional macro APPROX_MUL_EXACT_MODE_EN adds exact_i, which forces every HA to exact for one product.
module approx_ha_array_mul_seq #(
    parameter int WIDTH = 8,
    parameter logic [(WIDTH/2)*(WIDTH-1)*2-1:0] HA_MODE = '0
) (
    input  logic clk,
    input  logic rst_n,
`ifdef APPROX_MUL_EXACT_MODE_EN
    input  logic exact_i,
`endif
    approx_ha_array_mul_seq_if.slave bus
);

    localparam int PAIRS  = WIDTH / 2;
    localparam int KW     = $clog2(PAIRS);
    localparam int MODE_W = 2 * (WIDTH - 1);
    localparam logic [KW-1:0] K_LAST = KW'(PAIRS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [WIDTH-1:0]    x_q;
    logic [WIDTH-1:0]    y_q;
    logic [KW-1:0]       k_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic                in_ready_q;
    logic                out_valid_q;
`ifdef APPROX_MUL_EXACT_MODE_EN
    logic                exact_q;
`endif

    logic [MODE_W-1:0]   modes_k;
    logic                xa_k;
    logic                xb_k;
    logic [WIDTH+1:0]    v_k;
    logic [2*WIDTH-1:0]  addend;

    // Reduce one row pair through the HA row; returns t + (b << 2).
    function automatic logic [WIDTH+1:0] pair_value(
        input logic [WIDTH-1:0]  yv,
        input logic              xa,
        input logic              xb,
        input logic [MODE_W-1:0] modes
    );
        logic [WIDTH:0]   t;
        logic [WIDTH-2:0] b;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;
        logic             aj;
        logic             bj;
        t = '0;
        b = '0;
        s = '0;
        c = '0;
        for (int j = 1; j < WIDTH; j++) begin
            aj = yv[j] & xa;
            bj = yv[j-1] & xb;
            case (modes[2*(j-1) +: 2])
                2'b00:   begin s[j] = aj ^ bj; c[j] = aj & bj; end
                2'b01:   s[j] = aj | bj;
                2'b10:   c[j] = aj;
                default: ;
            endcase
        end
        t[0] = yv[0] & xa;
        for (int j = 1; j < WIDTH; j++) t[j] = s[j];
        t[WIDTH] = c[WIDTH-1];
        for (int i = 0; i <= WIDTH - 3; i++) b[i] = c[i+1];
        b[WIDTH-2] = yv[WIDTH-1] & xb;
        return {1'b0, t} + ({3'b000, b} << 2);
    endfunction

    always_comb begin
        modes_k = HA_MODE[MODE_W*int'(k_q) +: MODE_W];
`ifdef APPROX_MUL_EXACT_MODE_EN
        if (exact_q) modes_k = '0;
`endif
        xa_k   = x_q[2*k_q];
        xb_k   = x_q[2*k_q+1];
        v_k    = pair_value(y_q, xa_k, xb_k, modes_k);
        addend = {{(WIDTH-2){1'b0}}, v_k} << (2*k_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef APPROX_MUL_EXACT_MODE_EN
            exact_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q        <= bus.x;
                        y_q        <= bus.y;
                        k_q        <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
`ifdef APPROX_MUL_EXACT_MODE_EN
                        exact_q    <= exact_i;
`endif
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // Accumulation wraps modulo 2^(2*WIDTH); A-carry mode may overshoot.
                    acc_q <= acc_q + addend;
                    if (k_q == K_LAST) begin
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = acc_q;

endmodule

// File: tb/tb_approx_ha_array_mul_seq.sv
// Bench: four multipliers with different HA_MODE settings driven in lockstep, checked against a weight-sum model.
module tb_approx_ha_array_mul_seq;

    localparam int W  = 8;
    localparam int MW = (W/2)*(W-1)*2;
    localparam int NI = 4;
    localparam logic [NI-1:0][MW-1:0] MODES = {
        56'h9C_3A_E1_5B_72_D4_06,
        {MW{1'b1}},
        56'h1,
        56'h0
    };

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid;
    logic out_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic exact_i;

    logic [NI-1:0][2*W-1:0] p_w;
    logic [NI-1:0]          ov_w;
    logic [NI-1:0]          ir_w;

    int checks = 0;
    int failures = 0;
    logic [2*W-1:0] p_obs [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        approx_ha_array_mul_seq_if #(.WIDTH(W)) bus ();
        assign bus.in_valid  = in_valid;
        assign bus.x         = x;
        assign bus.y         = y;
        assign bus.out_ready = out_ready;
        assign p_w[gi]  = bus.p;
        assign ov_w[gi] = bus.out_valid;
        assign ir_w[gi] = bus.in_ready;
        approx_ha_array_mul_seq #(.WIDTH(W), .HA_MODE(MODES[gi])) dut (
            .clk     (clk),
            .rst_n   (rst_n),
`ifdef APPROX_MUL_EXACT_MODE_EN
            .exact_i (exact_i),
`endif
            .bus     (bus)
        );
    end

    // Sum every surviving bit at its arithmetic weight.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] xv, input logic [W-1:0] yv,
                                             input logic [MW-1:0] mode, input bit ex);
        longint unsigned sum;
        sum = 0;
        for (int k = 0; k < W/2; k++) begin
            int base;
            base = 2*k;
            sum += longint'(yv[0] & xv[2*k]) << base;
            sum += longint'(yv[W-1] & xv[2*k+1]) << (base + W);
            for (int j = 1; j < W; j++) begin
                bit a;
                bit b;
                logic [1:0] m;
                a = yv[j] & xv[2*k];
                b = yv[j-1] & xv[2*k+1];
                m = ex ? 2'b00 : mode[2*(k*(W-1)+j-1) +: 2];
                case (m)
                    2'b00: sum += (longint'(a ^ b) << (base + j)) + (longint'(a & b) << (base + j + 1));
                    2'b01: sum += longint'(a | b) << (base + j);
                    2'b10: sum += longint'(a) << (base + j + 1);
                    default: ;
                endcase
            end
        end
        return sum[2*W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_p(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv, input bit ex);
        for (int i = 0; i < NI; i++)
            chk($sformatf("%s_p%0d", tag, i), p_w[i], model(xv, yv, MODES[i], ex));
    endtask

    // One full transaction; hold = cycles of out_ready=0 after out_valid rises.
    task automatic do_txn(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                          input bit ex, input int hold);
        int lat;
        lat = 0;
        while (ir_w !== {NI{1'b1}}) begin
            @(posedge clk); #1;
            lat++;
            if (lat > 20) begin
                $display("FAIL %s_in_ready_timeout observed=%b expected=1111", tag, ir_w);
                $fatal(1, "in_ready timeout");
            end
        end
        @(negedge clk);
        in_valid  = 1'b1;
        x         = xv;
        y         = yv;
        exact_i   = ex;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x        = W'($urandom);
        y        = W'($urandom);
        exact_i  = ~ex;
        lat = 0;
        while (ov_w[0] !== 1'b1) begin
            @(posedge clk); #1;
            lat++;
            if (lat > 20) begin
                $display("FAIL %s_out_valid_timeout observed=%0d expected=4", tag, lat);
                $fatal(1, "out_valid timeout");
            end
        end
        chk({tag, "_latency"}, 16'(lat), 16'd4);
        chk({tag, "_ov_all"}, 16'(ov_w), 16'hF);
        chk_all_p(tag, xv, yv, ex);
        for (int i = 0; i < NI; i++) p_obs[i] = p_w[i];
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_ov"}, 16'(ov_w), 16'hF);
            chk({tag, "_hold_ir"}, 16'(ir_w), 16'h0);
            chk({tag, "_hold_p0"}, p_w[0], p_obs[0]);
            chk({tag, "_hold_p3"}, p_w[3], p_obs[3]);
        end
        if (hold > 0) begin
            @(negedge clk);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_ret_ov"}, 16'(ov_w), 16'h0);
        chk({tag, "_ret_ir"}, 16'(ir_w), 16'hF);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        x         = '0;
        y         = '0;
        exact_i   = 1'b0;
        #1 rst_n  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ir", 16'(ir_w), 16'hF);
        chk("rst_ov", 16'(ov_w), 16'h0);
        chk("rst_p0", p_w[0], 16'd0);
        chk("rst_p2", p_w[2], 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_txn("max", 8'd255, 8'd255, 1'b0, 0);
        chk("max_exact", p_obs[0], 16'd65025);
        chk("max_elim", p_obs[2], 16'd21845);
        chk("max_elim_noX", 16'($isunknown(p_obs[2])), 16'd0);

        do_txn("three", 8'd3, 8'd3, 1'b0, 0);
        chk("three_exact", p_obs[0], 16'd9);
        chk("three_or", p_obs[1], 16'd7);

        do_txn("bp", 8'd200, 8'd77, 1'b0, 10);
        do_txn("after_bp", 8'd19, 8'd230, 1'b0, 0);

        // Reset asserted two RUN edges after accept, away from any clock edge.
        @(negedge clk);
        in_valid  = 1'b1;
        x         = 8'd255;
        y         = 8'd255;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ir", 16'(ir_w), 16'hF);
        chk("midrst_ov", 16'(ov_w), 16'h0);
        chk("midrst_p0", p_w[0], 16'd0);
        chk("midrst_p3", p_w[3], 16'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b0;

`ifdef APPROX_MUL_EXACT_MODE_EN
        do_txn("post_rst", 8'd12, 8'd10, 1'b1, 0);
        chk("post_rst_120", p_obs[1], 16'd120);
        do_txn("ex_on", 8'd3, 8'd3, 1'b1, 0);
        chk("ex_on_or", p_obs[1], 16'd9);
        do_txn("ex_off", 8'd3, 8'd3, 1'b0, 0);
        chk("ex_off_or", p_obs[1], 16'd7);
`else
        do_txn("post_rst", 8'd12, 8'd10, 1'b0, 0);
        chk("post_rst_120", p_obs[0], 16'd120);
`endif

        for (int n = 0; n < 24; n++) begin
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            bit rex;
            rx = W'($urandom);
            ry = W'($urandom);
`ifdef APPROX_MUL_EXACT_MODE_EN
            rex = 1'($urandom_range(0, 1));
`else
            rex = 1'b0;
`endif
            do_txn($sformatf("rnd%0d", n), rx, ry, rex, int'($urandom_range(0, 3)));
            if (!rex) chk($sformatf("rnd%0d_prod", n), p_obs[0], 16'(rx * ry));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
